// File: rtl/ibex_dmem_responder_if.sv
// ibex_dmem_responder_if: core data bus, req/gnt request channel
// plus rvalid/rdata/err response channel.
interface ibex_dmem_responder_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ibex_dmem_responder.sv
// ibex_dmem_responder: data-bus RAM, fixed-latency in-order responses.
// Define IBEX_DMEM_ERR_INJ_EN to add the err_inj_i error-injection port.
module ibex_dmem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0001_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RvalidDelay    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef IBEX_DMEM_ERR_INJ_EN
  input  logic err_inj_i,
`endif
  ibex_dmem_responder_if.slave bus,
  output logic busy_o
);
  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned WW =
    (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam logic [WW-1:0] WaitMax = WW'(GntDelay);
  localparam logic [OW-1:0] OutMax  = OW'(MaxOutstanding);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic [31:0]   mem_q [MemWords];
  rsp_t          pipe_q [RvalidDelay];
  rsp_t          push;
  logic [WW-1:0] wait_q;
  logic [OW-1:0] out_q;
  logic [29:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          inj;
  logic          acc_err;
  logic          hs;
  logic          unused_bits;

  // Below-base addresses wrap to huge offsets and fail the compare.
  assign off      = bus.addr[31:2] - BaseAddr[31:2];
  assign in_range = {2'b00, off} < 32'(MemWords);
  assign idx      = off[AW-1:0];

`ifdef IBEX_DMEM_ERR_INJ_EN
  assign inj = err_inj_i;
`else
  assign inj = 1'b0;
`endif

  assign acc_err = ~in_range | inj;
  assign bus.gnt = bus.req
                 & (wait_q == WaitMax)
                 & (out_q < OutMax);
  assign hs      = bus.req & bus.gnt;

  always_comb begin
    push       = '0;
    push.valid = hs;
    push.err   = hs & acc_err;
    if (hs && !bus.we && !acc_err) begin
      push.rdata = mem_q[idx];
    end
  end

  assign bus.rvalid = pipe_q[RvalidDelay-1].valid;
  assign bus.err    = pipe_q[RvalidDelay-1].err;
  assign bus.rdata  = pipe_q[RvalidDelay-1].rdata;
  assign busy_o     = out_q != '0;

  assign unused_bits = ^{bus.addr[1:0], off[29:AW]};

  // Array is left unreset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (hs && bus.we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) begin
          mem_q[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RvalidDelay; i++) begin
        pipe_q[i] <= '0;
      end
      wait_q <= '0;
      out_q  <= '0;
    end else begin
      pipe_q[0] <= push;
      for (int i = 1; i < RvalidDelay; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end

      if (!bus.req || bus.gnt) begin
        wait_q <= '0;
      end else if (wait_q != WaitMax) begin
        wait_q <= wait_q + 1'b1;
      end

      unique case (1'b1)
        hs && !bus.rvalid: out_q <= out_q + 1'b1;
        !hs && bus.rvalid: out_q <= out_q - 1'b1;
        default:           out_q <= out_q;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_dmem_responder.sv
// tb_ibex_dmem_responder: directed checks on three parameterisations
// (defaults, GntDelay=2, RvalidDelay=3).
module tb_ibex_dmem_responder;
  logic clk = 1'b0;
  logic rst_ni;
  logic busy0, busy1, busy2;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ibex_dmem_responder_if b0 ();
  ibex_dmem_responder_if b1 ();
  ibex_dmem_responder_if b2 ();

  ibex_dmem_responder u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
`ifdef IBEX_DMEM_ERR_INJ_EN
    .err_inj_i (1'b0),
`endif
    .bus    (b0.slave),
    .busy_o (busy0)
  );

  ibex_dmem_responder #(.GntDelay(2)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
`ifdef IBEX_DMEM_ERR_INJ_EN
    .err_inj_i (1'b0),
`endif
    .bus    (b1.slave),
    .busy_o (busy1)
  );

  ibex_dmem_responder #(
    .RvalidDelay(3),
    .MaxOutstanding(2)
  ) u_dut2 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
`ifdef IBEX_DMEM_ERR_INJ_EN
    .err_inj_i (1'b0),
`endif
    .bus    (b2.slave),
    .busy_o (busy2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we,
                      input logic [31:0] addr,
                      input logic [3:0] be,
                      input logic [31:0] wdata);
    b0.req   = req;
    b0.we    = we;
    b0.addr  = addr;
    b0.be    = be;
    b0.wdata = wdata;
  endtask

  initial begin
    rst_ni = 1'b0;
    drv0(0, 0, 32'h0001_0000, 4'hF, 32'h0);
    b1.req = 0; b1.we = 0; b1.addr = 32'h0001_0000;
    b1.be = 4'hF; b1.wdata = 0;
    b2.req = 0; b2.we = 0; b2.addr = 32'h0001_0000;
    b2.be = 4'hF; b2.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    #1;
    chk("rst_gnt",    b0.gnt,    0);
    chk("rst_rvalid", b0.rvalid, 0);
    chk("rst_rdata",  b0.rdata,  0);
    chk("rst_err",    b0.err,    0);
    chk("rst_busy",   busy0,     0);

    // Defaults: full write, read back, partial write, range errors
    tick();
    drv0(1, 1, 32'h0001_0008, 4'hF, 32'hDEAD_BEEF);
    #1 chk("wr_gnt", b0.gnt, 1);
    tick();
    drv0(1, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1;
    chk("wr_rvalid", b0.rvalid, 1);
    chk("wr_rdata",  b0.rdata,  0);
    chk("wr_busy",   busy0,     1);
    chk("rd_gnt",    b0.gnt,    1);
    tick();
    drv0(1, 1, 32'h0001_0008, 4'b0100, 32'h00AA_0000);
    #1;
    chk("rd_rvalid", b0.rvalid, 1);
    chk("rd_rdata",  b0.rdata,  32'hDEAD_BEEF);
    chk("rd_err",    b0.err,    0);
    tick();
    drv0(1, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1 chk("pw_rvalid", b0.rvalid, 1);
    tick();
    drv0(1, 0, 32'h0000_FFFC, 4'hF, 32'h0);
    #1 chk("pw_rdata", b0.rdata, 32'hDEAA_BEEF);
    tick();
    drv0(1, 0, 32'h0001_1000, 4'hF, 32'h0);
    #1;
    chk("lo_err",   b0.err,   1);
    chk("lo_rdata", b0.rdata, 0);
    tick();
    drv0(1, 0, 32'h0001_0FFC, 4'hF, 32'h0);
    #1;
    chk("hi_err",   b0.err,   1);
    chk("hi_rdata", b0.rdata, 0);
    tick();
    drv0(1, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1 chk("top_err", b0.err, 0);
    tick();
    drv0(0, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1;
    chk("keep_rvalid", b0.rvalid, 1);
    chk("keep_rdata",  b0.rdata,  32'hDEAA_BEEF);
    tick();
    chk("idle_rvalid", b0.rvalid, 0);
    chk("idle_rdata",  b0.rdata,  0);
    chk("idle_busy",   busy0,     0);

    // GntDelay=2: grant in 3rd cycle, withdrawal clears wait
    tick();
    b1.req = 1;
    #1 chk("gd_c1", b1.gnt, 0);
    tick(); chk("gd_c2", b1.gnt, 0);
    tick(); chk("gd_c3", b1.gnt, 1);
    tick();
    b1.req = 0;
    #1;
    chk("gd_rvalid", b1.rvalid, 1);
    chk("gd_err",    b1.err,    0);
    tick();
    b1.req = 1;
    #1 chk("wd_gnt0", b1.gnt, 0);
    tick();
    b1.req = 0;
    #1 chk("wd_gnt1", b1.gnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_rvalid", b1.rvalid, 0);
    end
    chk("wd_busy", busy1, 0);
    tick();
    b1.req = 1;
    #1 chk("wd_r1", b1.gnt, 0);
    tick(); chk("wd_r2", b1.gnt, 0);
    tick(); chk("wd_r3", b1.gnt, 1);
    b1.req = 0;

    // RvalidDelay=3, MaxOutstanding=2
    tick();
    b2.req = 1; b2.we = 1; b2.addr = 32'h0001_0000;
    b2.be = 4'hF; b2.wdata = 32'hA5A5_A5A5;
    #1 chk("mo_g0", b2.gnt, 1);
    tick();
    b2.we = 0;
    #1;
    chk("mo_g1",   b2.gnt, 1);
    chk("mo_busy", busy2,  1);
    tick();
    chk("mo_g2",  b2.gnt,    0);
    chk("mo_rv_", b2.rvalid, 0);
    tick();
    chk("mo_rv0",  b2.rvalid, 1);
    chk("mo_rd0",  b2.rdata,  0);
    chk("mo_g3",   b2.gnt,    0);
    tick();
    chk("mo_rv1",  b2.rvalid, 1);
    chk("mo_rd1",  b2.rdata,  32'hA5A5_A5A5);
    chk("mo_g4",   b2.gnt,    1);
    b2.req = 0;
    tick();
    chk("mo_rvx",  b2.rvalid, 0);
    chk("mo_idle", busy2,     0);

    // Reset with two reads outstanding
    tick();
    b2.req = 1; b2.we = 0; b2.addr = 32'h0001_0000;
    #1 chk("rs_g0", b2.gnt, 1);
    tick(); chk("rs_g1", b2.gnt, 1);
    tick();
    b2.req = 0;
    #1 chk("rs_busy_pre", busy2, 1);
    rst_ni = 0;
    #1;
    chk("rs_rvalid", b2.rvalid, 0);
    chk("rs_rdata",  b2.rdata,  0);
    chk("rs_busy",   busy2,     0);
    tick();
    tick();
    rst_ni = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rs_norv", b2.rvalid, 0);
    end

    // Contents survive reset
    b2.req = 1;
    drv0(1, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1 chk("pr_gnt", b2.gnt, 1);
    tick();
    b2.req = 0;
    drv0(0, 0, 32'h0001_0008, 4'hF, 32'h0);
    #1 chk("pr_rd0", b0.rdata, 32'hDEAA_BEEF);
    tick();
    tick();
    chk("pr_rv2", b2.rvalid, 1);
    chk("pr_rd2", b2.rdata,  32'hA5A5_A5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
